// File: rtl/fetch_sum_core_if.sv
// Host loader bus for the program RAM's port A: address, write data, write enable and read-back.
interface fetch_sum_core_if #(
    parameter int unsigned OP_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH = 9
);
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [OP_WIDTH-1:0]   load_data;
    logic                  load_we;
    logic [OP_WIDTH-1:0]   load_rdata;

    modport master (output load_addr, output load_data, output load_we, input load_rdata);
    modport slave  (input load_addr, input load_data, input load_we, output load_rdata);
endinterface

// File: rtl/fetch_sum_core.sv
// Program-memory core: dual-port RAM with a host loader on port A and a fetch/accumulate
// datapath reading port B one word per running cycle.
module fetch_sum_core #(
    parameter int unsigned OP_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned N_WORD     = 512,
    parameter int unsigned SUM_WIDTH  = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 running,
    fetch_sum_core_if.slave      load_bus,
    output logic [SUM_WIDTH-1:0] ip,
    output logic [SUM_WIDTH-1:0] sum,
    output logic [9:0]           led
);

    logic [OP_WIDTH-1:0]   mem [N_WORD];
    logic [ADDR_WIDTH-1:0] addr_a_q;
    logic [ADDR_WIDTH-1:0] addr_b_q;
    logic                  running_q;
    logic [SUM_WIDTH-1:0]  next_ip;
    logic [OP_WIDTH-1:0]   q_b;

    // Port B address tracks next_ip so q_b is always mem[ip] during the cycle.
    assign next_ip             = running ? ip + SUM_WIDTH'(1) : '0;
    assign q_b                 = mem[addr_b_q];
    assign load_bus.load_rdata = mem[addr_a_q];

    // RAM array carries no reset; port A is the only writer.
    always_ff @(posedge clock) begin
        if (load_bus.load_we) begin
            mem[load_bus.load_addr] <= load_bus.load_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            running_q <= 1'b0;
            ip        <= '0;
            sum       <= '0;
        end else begin
            addr_a_q  <= load_bus.load_addr;
            addr_b_q  <= next_ip[ADDR_WIDTH-1:0];
            running_q <= running;
            ip        <= next_ip;
            sum       <= running ? sum + SUM_WIDTH'(q_b) : '0;
        end
    end

    assign led = {sum[3:0], running_q, 1'b0, ip[3:0]};

endmodule

// File: tb/tb_fetch_sum_core.sv
// Randomized self-checking bench for fetch_sum_core against a per-edge behavioural model.
module tb_fetch_sum_core;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        running = 1'b0;
    logic [31:0] ip;
    logic [31:0] sum;
    logic [9:0]  led;

    fetch_sum_core_if #(.OP_WIDTH(16), .ADDR_WIDTH(9)) lbus ();

    fetch_sum_core #(.OP_WIDTH(16), .ADDR_WIDTH(9), .N_WORD(512), .SUM_WIDTH(32)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .running  (running),
        .load_bus (lbus),
        .ip       (ip),
        .sum      (sum),
        .led      (led)
    );

    always #5 clock = ~clock;

    logic [15:0] mem_m [512];
    logic [31:0] ip_m;
    logic [31:0] sum_m;
    logic        run_q_m;
    logic [8:0]  rd_addr_m;
    logic [9:0]  led_m;
    int unsigned n_cmp;
    int unsigned n_bad;

    // One clock edge of the reference model, then wait past the edge.
    task automatic tick();
        if (running) begin
            sum_m = sum_m + 32'(mem_m[ip_m % 512]);
            ip_m  = ip_m + 1;
        end else begin
            sum_m = 0;
            ip_m  = 0;
        end
        run_q_m   = running;
        rd_addr_m = lbus.load_addr;
        if (lbus.load_we) mem_m[lbus.load_addr] = lbus.load_data;
        led_m = {sum_m[3:0], run_q_m, 1'b0, ip_m[3:0]};
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input logic [8:0] a, input logic [15:0] d);
        lbus.load_we   = 1'b1;
        lbus.load_addr = a;
        lbus.load_data = d;
        tick();
        lbus.load_we   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        running = 1'b0;
        lbus.load_we = 1'b0; lbus.load_addr = '0; lbus.load_data = '0;
        ip_m = 0; sum_m = 0; run_q_m = 0; rd_addr_m = 0;
        #22;
        n_cmp++; if (ip !== 32'd0)  begin n_bad++; $display("FAIL reset_ip got %h want 0", ip); end
        n_cmp++; if (sum !== 32'd0) begin n_bad++; $display("FAIL reset_sum got %h want 0", sum); end
        n_cmp++; if (led !== 10'd0) begin n_bad++; $display("FAIL reset_led got %h want 0", led); end
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_load_readback();
        for (int i = 0; i < 4; i++) write_word(9'(i), 16'(i + 1));
        lbus.load_addr = 9'd2;
        tick();
        n_cmp++; if (lbus.load_rdata !== 16'd3) begin n_bad++; $display("FAIL readback_addr2 got %h want 3", lbus.load_rdata); end
        for (int i = 4; i < 512; i++) write_word(9'(i), 16'($urandom));
        for (int i = 0; i < 8; i++) begin
            lbus.load_addr = 9'($urandom);
            tick();
            n_cmp++;
            if (lbus.load_rdata !== mem_m[rd_addr_m]) begin
                n_bad++; $display("FAIL readback_rand addr %0d got %h want %h", rd_addr_m, lbus.load_rdata, mem_m[rd_addr_m]);
            end
        end
        // Read-during-write returns the freshly written word.
        write_word(9'd300, 16'hBEEF);
        n_cmp++; if (lbus.load_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL rdw got %h want beef", lbus.load_rdata); end
    endtask

    task automatic test_run();
        running = 1'b1;
        repeat (4) tick();
        n_cmp++; if (sum !== 32'd10)     begin n_bad++; $display("FAIL run_sum got %0d want 10", sum); end
        n_cmp++; if (ip !== 32'd4)       begin n_bad++; $display("FAIL run_ip got %0d want 4", ip); end
        n_cmp++; if (led[9:6] !== 4'hA)  begin n_bad++; $display("FAIL run_led_sum got %h want a", led[9:6]); end
        n_cmp++; if (led[3:0] !== 4'h4)  begin n_bad++; $display("FAIL run_led_ip got %h want 4", led[3:0]); end
        n_cmp++; if (led[5] !== 1'b1)    begin n_bad++; $display("FAIL run_led_running got %b want 1", led[5]); end
    endtask

    task automatic test_stop_restart();
        running = 1'b0;
        tick();
        n_cmp++; if (sum !== 32'd0) begin n_bad++; $display("FAIL stop_sum got %0d want 0", sum); end
        n_cmp++; if (ip !== 32'd0)  begin n_bad++; $display("FAIL stop_ip got %0d want 0", ip); end
        running = 1'b1;
        repeat (2) tick();
        n_cmp++; if (sum !== 32'd3) begin n_bad++; $display("FAIL restart_sum got %0d want 3", sum); end
        n_cmp++; if (ip !== 32'd2)  begin n_bad++; $display("FAIL restart_ip got %0d want 2", ip); end
    endtask

    task automatic test_collision();
        // ip=2 here; write the word that the following edge will fetch.
        write_word(9'd3, 16'h0100);
        tick();
        n_cmp++; if (sum !== 32'h106) begin n_bad++; $display("FAIL collision_sum got %h want 106", sum); end
        n_cmp++; if (sum !== sum_m)   begin n_bad++; $display("FAIL collision_model got %h want %h", sum, sum_m); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            running = ($urandom_range(0, 9) != 0);
            lbus.load_we = ($urandom_range(0, 2) == 0);
            lbus.load_addr = ($urandom_range(0, 3) == 0) ? 9'(ip_m + 1) : 9'($urandom);
            if ($urandom_range(0, 3) == 0) lbus.load_addr = 9'(ip_m);
            lbus.load_data = 16'($urandom);
            tick();
            n_cmp++; if (ip !== ip_m)   begin n_bad++; $display("FAIL rand_ip cyc %0d got %h want %h", c, ip, ip_m); end
            n_cmp++; if (sum !== sum_m) begin n_bad++; $display("FAIL rand_sum cyc %0d got %h want %h", c, sum, sum_m); end
            n_cmp++; if (led !== led_m) begin n_bad++; $display("FAIL rand_led cyc %0d got %h want %h", c, led, led_m); end
            n_cmp++;
            if (lbus.load_rdata !== mem_m[rd_addr_m]) begin
                n_bad++; $display("FAIL rand_rdata cyc %0d got %h want %h", c, lbus.load_rdata, mem_m[rd_addr_m]);
            end
        end
        lbus.load_we = 1'b0;
    endtask

    task automatic test_wrap();
        running = 1'b0;
        for (int i = 0; i < 512; i++) write_word(9'(i), 16'hFFFF);
        running = 1'b1;
        repeat (513) tick();
        n_cmp++; if (ip !== 32'd513)        begin n_bad++; $display("FAIL wrap_ip got %0d want 513", ip); end
        n_cmp++; if (sum !== 32'h0200FDFF)  begin n_bad++; $display("FAIL wrap_sum got %h want 0200fdff", sum); end
        n_cmp++; if (sum !== sum_m)         begin n_bad++; $display("FAIL wrap_model got %h want %h", sum, sum_m); end
    endtask

    task automatic test_async_reset();
        logic [15:0] seq [7];
        seq = '{16'h10, 16'h10, 16'h10, 16'h10, 16'h10, 16'h05, 16'h00};
        running = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) write_word(9'(i), seq[i]);
        running = 1'b1;
        repeat (7) tick();
        n_cmp++; if (ip !== 32'd7)      begin n_bad++; $display("FAIL prereset_ip got %0d want 7", ip); end
        n_cmp++; if (sum !== 32'h55)    begin n_bad++; $display("FAIL prereset_sum got %h want 55", sum); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (ip !== 32'd0)  begin n_bad++; $display("FAIL async_ip got %h want 0", ip); end
        n_cmp++; if (sum !== 32'd0) begin n_bad++; $display("FAIL async_sum got %h want 0", sum); end
        n_cmp++; if (led !== 10'd0) begin n_bad++; $display("FAIL async_led got %h want 0", led); end
        n_cmp++; if (lbus.load_rdata !== mem_m[0]) begin n_bad++; $display("FAIL async_rdata got %h want %h", lbus.load_rdata, mem_m[0]); end
        running = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        ip_m = 0; sum_m = 0; run_q_m = 0; rd_addr_m = 0;
        running = 1'b1;
        repeat (3) tick();
        n_cmp++; if (sum !== 32'h30) begin n_bad++; $display("FAIL postreset_sum got %h want 30", sum); end
        n_cmp++; if (led !== led_m)  begin n_bad++; $display("FAIL postreset_led got %h want %h", led, led_m); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_load_readback();
        test_run();
        test_stop_restart();
        test_collision();
        test_random();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_sum_core.md
Name: fetch_sum_core

Overview:
- Self-contained program-memory core: a 512x16 dual-port synchronous RAM plus an instruction-pointer/accumulator datapath, all on one clock.
- Port A of the RAM is a host loader interface (write/read-back). Port B is read-only and owned by the core.
- While the run control is high, the core fetches one word per cycle and accumulates it into a 32-bit sum. Status is mirrored onto a 10-bit LED bus.

Parameters:
- OP_WIDTH, 16, RAM word width and width of each fetched op
- ADDR_WIDTH, 9, RAM address width
- N_WORD, 512, RAM depth; must equal 2**ADDR_WIDTH
- SUM_WIDTH, 32, width of ip and sum registers

Ports:
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- running  in  1  core run control (1 = run, 0 = hold in cleared state)
- load_addr  in  ADDR_WIDTH  loader (port A) address
- load_data  in  OP_WIDTH  loader write data
- load_we  in  1  loader write enable, one word per cycle while high
- load_rdata  out  OP_WIDTH  loader read data (port A q)
- ip  out  SUM_WIDTH  current instruction pointer
- sum  out  SUM_WIDTH  accumulator
- led  out  10  status display

Behaviour:
- Reset (reset_n=0, async assert, sync-free release):
  - ip=0, sum=0, port A and port B address registers=0, running_q=0.
  - RAM contents are not reset (power-up uninitialized; X in simulation).
- RAM port A:
  - Address, data and we are registered on the rising clock edge. Output is unregistered from the address register.
  - load_rdata = mem[addr captured at last edge], i.e. 1-cycle read latency.
  - Write with load_we=1 takes effect at the edge. Read-during-write on port A returns the new data.
- RAM port B:
  - Read-only; write enable is tied 0.
  - The address register loads next_ip[ADDR_WIDTH-1:0], where next_ip = running ? ip+1 : 0.
  - Therefore q_b always equals mem[ip[ADDR_WIDTH-1:0]] during the cycle.
- Port collision: a port-A write to the address currently held in the port-B address register makes q_b show the new data from the cycle after the write edge.
- Core, each rising edge:
  - running=1: sum <= sum + zero-extend(q_b); ip <= ip + 1.
  - running=0: ip <= 0; sum <= 0. This is a synchronous clear, and the core holds while running stays low.
- Fetch sequence: the Nth consecutive running edge (N=1,2,...) adds mem[(N-1) mod N_WORD]. No duplicate or skipped fetch on the 0->1 transition of running.
- Wrap-around:
  - ip wraps modulo 2**SUM_WIDTH. The RAM address is ip[ADDR_WIDTH-1:0], so it wraps at 511->0.
  - sum wraps modulo 2**SUM_WIDTH; there is no saturation and no overflow flag.
- Dropping running mid-operation: the next edge clears ip and sum. Re-asserting running restarts from mem[0].
- Register running into running_q each edge.
- led (combinational from registers only):
  - led[9:6] = sum[3:0]
  - led[5] = running_q
  - led[4] = 0
  - led[3:0] = ip[3:0]
- Loader activity never stalls or alters the core datapath except through memory contents.

Test Plan:
- Reset: assert reset_n=0 mid-run with ip=7, sum=0x55 -> ip, sum and led go to 0 immediately, without waiting for a clock edge.
- Load/readback: write mem[0..3] = 1,2,3,4 with load_we, then read addr 2 -> load_rdata=3 exactly one cycle after the address is presented.
- Run: with mem[0..3]=1,2,3,4, set running=1 for 4 edges -> sum=10, ip=4, led[9:6]=0xA, led[3:0]=4.
- Stop/restart: drop running for 1 edge -> sum=0, ip=0. Re-run 2 edges -> sum=3, with mem[0] not double-counted.
- Wrap: fill mem with 0xFFFF and run 513 edges -> ip=513, RAM address wraps to 1, sum = 513*0xFFFF mod 2**32 = 0x0200FDFF.
- Collision: while running, write 0x0100 to the next fetch address -> the new value is accumulated on the following edge.
